rs_shared_addsub: RTL and testbench

Parametrised resource-sharing arithmetic unit: NCH independent requesters time-share one WIDTH-bit add/subtract datapath through a round-robin arbiter and a two-stage pipeline. Each channel gets its own registered result and a one-cycle completion strobe. It sits wherever several operand pairs need an adder but area allows only one. It generalises the fixed two-select shared-adder block to N channels, handshaking and pipelining.

---
 rtl/rs_shared_addsub.sv | 140 ++++++++++++++
 tb/tb_rs_shared_addsub.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs_shared_addsub.sv
// rs_shared_addsub
//   NCH requesters time-share one WIDTH-bit add/subtract datapath. A
//   round-robin arbiter grants at most one channel per cycle. The granted
//   operands are registered in stage 1. Stage 2 computes the result and
//   writes it into that channel's result register, together with a
//   one-cycle completion strobe.
//
//   Optional feature macro: RS_SATURATE_EN
//     defined   -> saturating arithmetic. An add that overflows yields all
//                  ones and a subtract that borrows yields zero. res_flag
//                  marks that a clamp occurred.
//     undefined -> modular arithmetic. res_flag is the raw carry (add) or
//                  borrow (sub).
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   NCH    number of channels (2..16)
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [NCH]        channel has an operation pending
//   req_ready  [NCH]        channel granted this cycle (combinational)
//   op_a       [NCH*WIDTH]  operand A, channel i at [i*WIDTH +: WIDTH]
//   op_b       [NCH*WIDTH]  operand B, same packing
//   op_sub     [NCH]        1 = A-B, 0 = A+B
//   res_valid  [NCH]        one-cycle strobe, channel result updated
//   res_data   [NCH*WIDTH]  registered result per channel
//   res_flag   [NCH]        carry/borrow (or clamp) of the last result
module rs_shared_addsub #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       req_valid,
  output logic [NCH-1:0]       req_ready,
  input  logic [NCH*WIDTH-1:0] op_a,
  input  logic [NCH*WIDTH-1:0] op_b,
  input  logic [NCH-1:0]       op_sub,
  output logic [NCH-1:0]       res_valid,
  output logic [NCH*WIDTH-1:0] res_data,
  output logic [NCH-1:0]       res_flag
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  // Raw add/sub in WIDTH+1 bits; returns {flag, result}. Subtraction is
  // A + ~B + 1, so a missing carry out of the top bit means a borrow.
  function automatic logic [WIDTH:0] addsub_fn(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             sub);
    logic [WIDTH:0] raw;
    logic           flag;
    raw  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{WIDTH{1'b0}}, sub};
    flag = sub ? ~raw[WIDTH] : raw[WIDTH];
    return {flag, raw[WIDTH-1:0]};
  endfunction

  // Clamp on carry/borrow: overflow goes to all ones, underflow goes to zero.
  function automatic logic [WIDTH:0] sat_fn(input logic [WIDTH:0] r,
                                            input logic           sub);
`ifdef RS_SATURATE_EN
    if (r[WIDTH])
      return {1'b1, (sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}})};
    else
      return r;
`else
    if (sub) return r;   // wrap arithmetic: pass through unchanged
    else     return r;
`endif
  endfunction

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gidx;
  logic             found;

  logic             vld_p1;
  logic [PW-1:0]    id_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic             sub_p1;
  logic [WIDTH:0]   res_p1;

  // Arbitration: the first valid channel at or after ptr, wrapping.
  always_comb begin
    int idx;
    found     = 1'b0;
    gidx      = '0;
    req_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gidx  = idx[PW-1:0];
      end
    end
    if (found) req_ready[gidx] = 1'b1;
  end

  // ---- stage 0 -> stage 1: accept and register operands ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= found;
      if (found)
        ptr <= (gidx == PW'(NCH - 1)) ? '0 : gidx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (found) begin
      id_p1  <= gidx;
      a_p1   <= op_a[int'(gidx)*WIDTH +: WIDTH];
      b_p1   <= op_b[int'(gidx)*WIDTH +: WIDTH];
      sub_p1 <= op_sub[gidx];
    end
  end

  assign res_p1 = sat_fn(addsub_fn(a_p1, b_p1, sub_p1), sub_p1);

  // ---- stage 1 -> stage 2: per-channel result registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= '0;
      res_data  <= '0;
      res_flag  <= '0;
    end else begin
      res_valid <= '0;
      if (vld_p1) begin
        res_valid[id_p1]                       <= 1'b1;
        res_flag[id_p1]                        <= res_p1[WIDTH];
        res_data[int'(id_p1)*WIDTH +: WIDTH]   <= res_p1[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_rs_shared_addsub.sv
module tb_rs_shared_addsub;

  localparam int W = 8;
  localparam int N = 4;

`ifdef RS_SATURATE_EN
  localparam logic [7:0] E_200_100 = 8'd255;
  localparam logic [7:0] E_5_9     = 8'd0;
  localparam logic [7:0] E_255_1   = 8'd255;
`else
  localparam logic [7:0] E_200_100 = 8'd44;
  localparam logic [7:0] E_5_9     = 8'd252;
  localparam logic [7:0] E_255_1   = 8'd0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] op_a;
  logic [N*W-1:0] op_b;
  logic [N-1:0]   op_sub;
  logic [N-1:0]   res_valid;
  logic [N*W-1:0] res_data;
  logic [N-1:0]   res_flag;

  int n_chk  = 0;
  int n_fail = 0;

  rs_shared_addsub #(.WIDTH(W), .NCH(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_flag  (res_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int ch, input logic [7:0] a, input logic [7:0] b, input logic sub);
    op_a[ch*W +: W] = a;
    op_b[ch*W +: W] = b;
    op_sub[ch]      = sub;
  endtask

  function automatic logic [7:0] rd(input int ch);
    return res_data[ch*W +: W];
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = '0;
    tick();
    tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_flag", res_flag, 0);

    // Arbiter is combinational even in reset; state must not move.
    req_valid = 4'b0100;
    #1;
    chk("rst_ready_ch2", req_ready, 4'b0100);
    tick();
    chk("rst_hold_valid", res_valid, 0);
    chk("rst_hold_data", res_data, 0);
    req_valid = '0;
    rst_n     = 1'b1;
    tick();

    // ch0: 200 + 100
    set_op(0, 8'd200, 8'd100, 1'b0);
    req_valid = 4'b0001;
    #1;
    chk("add_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("add_lat_n", res_valid, 0);
    tick();
    chk("add_valid", res_valid, 4'b0001);
    chk("add_data", rd(0), E_200_100);
    chk("add_flag", res_flag[0], 1);
    tick();
    chk("add_strobe_end", res_valid, 0);
    chk("add_data_held", rd(0), E_200_100);

    // ch2: 5 - 9 (ptr=1)
    set_op(2, 8'd5, 8'd9, 1'b1);
    req_valid = 4'b0100;
    #1;
    chk("sub_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    chk("sub_valid", res_valid, 4'b0100);
    chk("sub_borrow_data", rd(2), E_5_9);
    chk("sub_borrow_flag", res_flag[2], 1);
    chk("sub_ch0_untouched", rd(0), E_200_100);

    // ch2: 9 - 5 (ptr=3, search wraps to 2)
    set_op(2, 8'd9, 8'd5, 1'b1);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    chk("sub2_data", rd(2), 4);
    chk("sub2_flag", res_flag[2], 0);

    // Pointer wrap: grant ch3 then present 1001.
    set_op(3, 8'd255, 8'd1, 1'b0);
    set_op(0, 8'd10, 8'd20, 1'b0);
    req_valid = 4'b1000;
    #1;
    chk("wrap_ready_ch3", req_ready, 4'b1000);
    tick();
    req_valid = 4'b1001;
    #1;
    chk("wrap_ready_ch0", req_ready, 4'b0001);
    tick();
    chk("wrap_res_ch3", res_valid, 4'b1000);
    chk("wrap_data_ch3", rd(3), E_255_1);
    chk("wrap_flag_ch3", res_flag[3], 1);
    chk("wrap_ready_ch3b", req_ready, 4'b1000);
    tick();
    chk("wrap_res_ch0", res_valid, 4'b0001);
    chk("wrap_data_ch0", rd(0), 30);
    chk("wrap_flag_ch0", res_flag[0], 0);
    req_valid = '0;
    tick();
    chk("wrap_res_ch3b", res_valid, 4'b1000);
    tick();
    chk("wrap_idle", res_valid, 0);

    // Fresh reset, then all four channels valid for 6 cycles.
    rst_n = 1'b0;
    tick();
    chk("rst2_data", res_data, 0);
    chk("rst2_flag", res_flag, 0);
    rst_n = 1'b1;
    for (int c = 0; c < N; c++) set_op(c, 8'(16 * c), 8'd1, 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", req_ready, 32'(1 << (k % 4)));
      tick();
      if (k == 0) begin
        chk("rr_res_first", res_valid, 0);
      end else begin
        chk("rr_res", res_valid, 32'(1 << ((k - 1) % 4)));
        chk("rr_data", rd((k - 1) % 4), 32'(16 * ((k - 1) % 4) + 1));
      end
    end
    req_valid = '0;
    tick();
    chk("rr_res_last", res_valid, 4'b0010);
    tick();
    chk("rr_idle", res_valid, 0);

    // Single requester ch1 back-to-back with changing operands (ptr=2).
    set_op(1, 8'd1, 8'd0, 1'b0);
    req_valid = 4'b0010;
    #1;
    chk("b2b_ready1", req_ready, 4'b0010);
    tick();
    chk("b2b_res0", res_valid, 0);
    set_op(1, 8'd2, 8'd0, 1'b0);
    #1;
    chk("b2b_ready2", req_ready, 4'b0010);
    tick();
    chk("b2b_res1", res_valid, 4'b0010);
    chk("b2b_data1", rd(1), 1);
    set_op(1, 8'd3, 8'd0, 1'b0);
    tick();
    chk("b2b_res2", res_valid, 4'b0010);
    chk("b2b_data2", rd(1), 2);
    req_valid = '0;
    set_op(1, 8'd99, 8'd0, 1'b0);
    tick();
    chk("b2b_res3", res_valid, 4'b0010);
    chk("b2b_data3_sampled", rd(1), 3);
    tick();
    chk("b2b_idle", res_valid, 0);

    // Reset between accept and result: the in-flight op is dropped.
    set_op(1, 8'd7, 8'd8, 1'b0);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", res_valid, 0);
    chk("midrst_data", rd(1), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_no_res", res_valid, 0);
    chk("midrst_data_after", rd(1), 0);
    tick();
    chk("midrst_no_res2", res_valid, 0);
    req_valid = 4'b1111;
    #1;
    chk("midrst_ptr0", req_ready, 4'b0001);
    req_valid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
